mips_data_memory: RTL and testbench
===================================

Name: mips_data_memory

Overview:
Responder on the CPU data-memory port. It answers `data_memory_a`/`data_memory_we`/`data_memory_wd` with `data_memory_rd` in the same cycle. Word RAM sits below `MMIO_BASE`; above it is a small MMIO window holding a free-running cycle counter and a transmit FIFO. The FIFO drains to an external consumer (console or testbench) over a valid/ready stream.

Parameters:
MEM_WORDS, 1024, RAM depth in 32-bit words; power of two.
FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2.
MMIO_BASE, 32'hFFFF0000, base byte address of the MMIO window.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous reset, active-high
a  input  32  byte address from CPU (`data_memory_a`)
we  input  1  write enable from CPU (`data_memory_we`)
wd  input  32  write data from CPU (`data_memory_wd`)
rd  output  32  read data to CPU (`data_memory_rd`), combinational
out_data  output  32  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head this cycle

Behaviour:
- Address decode: `a[1:0]` ignored (word access only). MMIO selected when `a[31:4] == MMIO_BASE[31:4]`; otherwise RAM at index `a[log2(MEM_WORDS)+1:2]`. Upper bits alias modulo `MEM_WORDS`.
- Reads: `rd` is a pure combinational function of `a` and current state, with zero latency, because the CPU is single-cycle. RAM reads return the stored word.
- MMIO map (offset from `MMIO_BASE`):
  - 0x0 CYCLE: read returns counter. Write loads `wd`.
  - 0x4 TXDATA: read returns 0. Write pushes `wd`.
  - 0x8 STATUS, read-only: [31:16] drop_cnt, [15:8] fifo count, [1] full, [0] empty, other bits 0.
  - 0xC and unused offsets: read 0, writes ignored.
- Writes: take effect at the posedge with `we=1`. A RAM write is visible on `rd` in the following cycle. Writing STATUS is ignored.
- RAM contents are not reset. Simulation initialises them to 0.
- Cycle counter: increments by 1 every posedge and wraps 32'hFFFFFFFF -> 0. A CPU write wins over the increment: the next value is `wd`, not `wd+1`.
- TX FIFO:
  - Circular buffer with read/write pointers plus a count of width log2(FIFO_DEPTH)+1.
  - Push = `we` && TXDATA selected. Pop = `out_valid` && `out_ready`.
  - `out_valid = (count != 0)`. `out_data` = entry at the read pointer; value undefined-but-stable when empty, driven 0 by implementation.
  - Push when full and no pop: data dropped, FIFO unchanged, drop_cnt += 1, saturating at 16'hFFFF.
  - Push and pop in the same cycle when full: both happen, count unchanged, no drop.
  - Push and pop in the same cycle when empty: push only (`out_valid` was 0), count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (async, active-high), effective immediately and held while high:
  - counter=0, FIFO count=0, pointers=0, drop_cnt=0.
  - Outputs: `out_valid=0`, `out_data=0`.
  - `rd` reflects the reset state.
  - No pushes, pops or RAM writes occur while `reset=1`.
- Reset mid-stream: FIFO contents are discarded. The consumer sees `out_valid` drop in the same cycle reset asserts.

Decomposition:
- Shared header `mips_defs.vh`:
  - MMIO offset constants: OFS_CYCLE=0, OFS_TXDATA=4, OFS_STATUS=8.
  - STATUS bit positions.
- Sub-module `sync_fifo`:
  - Parameters WIDTH, DEPTH.
  - Ports clk, reset, push, din, pop, dout, count, full, empty.
  - Same reset and simultaneous-push/pop rules as above.
  - Drop counting stays in `mips_data_memory`.

Test Plan:
- RAM write/read: write 32'hDEADBEEF at a=0x10 -> next cycle `rd`=DEADBEEF at a=0x10 and at a=0x13. `rd` at a=0x14 stays 0. Aliasing: a=0x10+4*MEM_WORDS reads DEADBEEF.
- Cycle counter: release reset, wait 10 posedges -> read 0xFFFF0000 returns 10. Write 32'hFFFFFFFE -> reads FFFFFFFE, then FFFFFFFF, then 0.
- FIFO fill/overflow (`out_ready=0`):
  - Push 1,2,3,4 -> STATUS = 0x0000_0402.
  - Push 5 -> STATUS = 0x0001_0402.
  - Raise `out_ready` -> `out_data` streams 1,2,3,4 on consecutive cycles, then `out_valid=0`, STATUS = 0x0001_0001.
- Simultaneous events:
  - Full FIFO, push 9 with `out_ready=1` -> count stays 4, drop_cnt unchanged, 9 emerges last.
  - Empty FIFO, push with `out_ready=1` -> `out_valid=1` the next cycle.
- Reset mid-operation: 3 entries queued and counter=500, assert reset between clock edges -> `out_valid=0` immediately, STATUS=0x0000_0001, CYCLE=0; a RAM word written earlier still reads back unchanged.

Source files
------------

// File: rtl/mips_data_memory_pkg.sv
// Shared MMIO register map and STATUS layout for the data-memory responder.
package mips_data_memory_pkg;

  localparam logic [3:0] OFS_CYCLE  = 4'h0;
  localparam logic [3:0] OFS_TXDATA = 4'h4;
  localparam logic [3:0] OFS_STATUS = 4'h8;

  typedef enum logic [1:0] {
    REG_CYCLE  = OFS_CYCLE[3:2],
    REG_TXDATA = OFS_TXDATA[3:2],
    REG_STATUS = OFS_STATUS[3:2],
    REG_RSVD   = 2'd3
  } mmio_reg_e;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 8;
  localparam int STAT_DROP_LSB  = 16;
  localparam int STAT_DROP_W    = 16;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with a separate occupancy count; a pop frees room for a
// push in the same cycle, and an empty FIFO never pops.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Pointer width equals log2(DEPTH), so increments wrap on their own.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mips_data_memory.sv
// Single-cycle CPU data-memory responder: word RAM below MMIO_BASE, and an MMIO
// window with a cycle counter and a TX FIFO streamed out over valid/ready.
module mips_data_memory
  import mips_data_memory_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] ram [MEM_WORDS];
  logic [31:0] cycle_q, cycle_d;
  logic [STAT_DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic            mmio_sel;
  mmio_reg_e       reg_sel;
  logic            cycle_wr, tx_push, tx_pop, ram_we, tx_drop;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic [31:0]     status;
  logic            unused_addr_lsbs;

  assign unused_addr_lsbs = ^a[1:0];

  assign mmio_sel = (a[31:4] == MMIO_BASE[31:4]);
  assign reg_sel  = mmio_reg_e'(a[3:2]);
  assign cycle_wr = we && mmio_sel && (reg_sel == REG_CYCLE);
  assign tx_push  = we && mmio_sel && (reg_sel == REG_TXDATA);
  assign ram_we   = we && !mmio_sel && !reset;
  assign tx_pop   = out_valid && out_ready;
  assign tx_drop  = tx_push && fifo_full && !tx_pop;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (wd),
    .pop   (tx_pop),
    .dout  (out_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;

  always_comb begin
    cycle_d    = cycle_wr ? wd : cycle_q + 32'd1;
    drop_cnt_d = drop_cnt_q;
    // Saturate rather than wrap so a flood of drops is never hidden.
    if (tx_drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      cycle_q    <= cycle_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[a[AW+1:2]] <= wd;
  end

  always_comb begin
    status = '0;
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
    status[STAT_DROP_LSB +: STAT_DROP_W]   = drop_cnt_q;
  end

  always_comb begin
    rd = '0;
    if (mmio_sel) begin
      unique case (reg_sel)
        REG_CYCLE:  rd = cycle_q;
        REG_STATUS: rd = status;
        default:    rd = '0;
      endcase
    end else begin
      rd = ram[a[AW+1:2]];
    end
  end

endmodule

// File: tb/tb_mips_data_memory.sv
// Directed bench for mips_data_memory with a queue/array reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_mips_data_memory;

  localparam int          MEM_WORDS  = 1024;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] BASE       = 32'hFFFF0000;
  localparam logic [31:0] A_CYCLE    = BASE + 32'h0;
  localparam logic [31:0] A_TX       = BASE + 32'h4;
  localparam logic [31:0] A_STATUS   = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  mips_data_memory #(
    .MEM_WORDS  (MEM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MMIO_BASE  (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .we        (we),
    .wd        (wd),
    .rd        (rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: behaviour expressed with a queue, an associative RAM and plain counters.
  logic [31:0] m_ram [int];
  logic [31:0] m_q [$];
  logic [31:0] m_cyc = '0;
  int          m_drop = 0;

  function automatic bit is_mmio(input logic [31:0] addr);
    return (addr >= BASE) && (addr <= BASE + 32'hF);
  endfunction

  function automatic int ram_idx(input logic [31:0] addr);
    return int'((addr / 4) % MEM_WORDS);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    int ofs;
    if (!is_mmio(addr)) return m_ram.exists(ram_idx(addr)) ? m_ram[ram_idx(addr)] : 32'h0;
    ofs = int'(addr - BASE) / 4 * 4;
    if (ofs == 0) return m_cyc;
    if (ofs == 8) return (m_drop * 65536) + (m_q.size() * 256)
                         + ((m_q.size() == FIFO_DEPTH) ? 2 : 0) + ((m_q.size() == 0) ? 1 : 0);
    return 32'h0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_cyc  = '0;
      m_drop = 0;
    end else begin
      bit do_pop, do_push;
      do_pop  = (m_q.size() > 0) && out_ready;
      do_push = we && is_mmio(a) && ((a - BASE) / 4 == 1);
      if (we && !is_mmio(a)) m_ram[ram_idx(a)] = wd;
      if (we && is_mmio(a) && ((a - BASE) / 4 == 0)) m_cyc = wd;
      else m_cyc = m_cyc + 32'd1;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(wd);
        else if (m_drop < 65535) m_drop = m_drop + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("model_rd", rd, model_rd(a));
      chk("model_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      chk("model_out_data", out_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
    end
  end

  task automatic go();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    a = addr; we = 1'b1; wd = data;
    go();
    we = 1'b0;
    $display("WR  a=%h d=%h", addr, data);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    a = addr;
    @(negedge clk);
    chk(name, rd, exp);
    $display("RD  a=%h rd=%h", addr, rd);
    go();
  endtask

  task automatic stream_chk(input string name, input logic [31:0] exp);
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_data"}, out_data, exp);
    $display("POP d=%h", out_data);
  endtask

  initial begin
    repeat (2) go();
    checking = 1'b1;
    a = A_STATUS;
    @(negedge clk);
    chk("reset_status", rd, 32'h0000_0001);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    go();

    // Counter counts posedges from reset release.
    reset = 1'b0;
    a = A_CYCLE;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("cycle_after_10", rd, 32'd10);
    go();
    wr(A_CYCLE, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("cycle_load", rd, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("cycle_inc", rd, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("cycle_wrap", rd, 32'h0);
    go();

    // RAM write, byte-offset ignore, neighbour untouched, aliasing.
    wr(32'h14, 32'h0);
    wr(32'h10, 32'hDEAD_BEEF);
    rd_chk("ram_rd", 32'h10, 32'hDEAD_BEEF);
    rd_chk("ram_rd_lsb", 32'h13, 32'hDEAD_BEEF);
    rd_chk("ram_neighbour", 32'h14, 32'h0);
    rd_chk("ram_alias", 32'h10 + 4 * MEM_WORDS, 32'hDEAD_BEEF);
    rd_chk("mmio_txdata_reads0", A_TX, 32'h0);

    // Fill, overflow, drain.
    for (int i = 1; i <= 4; i++) wr(A_TX, 32'(i));
    rd_chk("status_full", A_STATUS, 32'h0000_0402);
    wr(A_TX, 32'd5);
    rd_chk("status_drop", A_STATUS, 32'h0001_0402);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) stream_chk("drain", 32'(i));
    @(negedge clk);
    chk("drain_empty_valid", 32'(out_valid), 32'd0);
    chk("drain_status", rd, 32'h0001_0001);
    go();
    out_ready = 1'b0;

    // Push and pop together on a full FIFO.
    for (int i = 5; i <= 8; i++) wr(A_TX, 32'(i));
    a = A_TX; we = 1'b1; wd = 32'd9; out_ready = 1'b1;
    go();
    we = 1'b0; out_ready = 1'b0; a = A_STATUS;
    @(negedge clk);
    chk("full_pushpop_status", rd, 32'h0001_0402);
    go();
    out_ready = 1'b1;
    for (int i = 6; i <= 9; i++) stream_chk("full_pushpop", 32'(i));
    @(negedge clk);
    chk("full_pushpop_empty", 32'(out_valid), 32'd0);
    go();

    // Push into an empty FIFO while the consumer is ready.
    wr(A_TX, 32'h55);
    @(negedge clk);
    chk("empty_push_valid", 32'(out_valid), 32'd1);
    chk("empty_push_data", out_data, 32'h55);
    go();
    out_ready = 1'b0;

    // Reset between clock edges with traffic queued.
    wr(A_TX, 32'hA1);
    wr(A_TX, 32'hA2);
    wr(A_TX, 32'hA3);
    wr(A_CYCLE, 32'd500);
    a = A_CYCLE;
    #1;
    chk("cycle_500", rd, 32'd500);
    a = A_STATUS;
    #1;
    chk("pre_reset_status", rd, 32'h0001_0300);
    reset = 1'b1;
    #1;
    chk("reset_mid_valid", 32'(out_valid), 32'd0);
    chk("reset_mid_status", rd, 32'h0000_0001);
    a = A_CYCLE;
    #1;
    chk("reset_mid_cycle", rd, 32'h0);
    $display("RST asserted mid-stream");
    go();
    go();
    reset = 1'b0;
    rd_chk("ram_survives_reset", 32'h10, 32'hDEAD_BEEF);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
